// File: rtl/ipm_pkg.sv
// Shared definitions for the IPM decoder: FSM state encoding and the GF(2^8)
// reduction polynomial used by the share multiplier.
package ipm_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } ipm_state_t;

  localparam logic [8:0] GF_POLY = 9'h11B;

endpackage

// File: rtl/ipm_decode_serial_gmul8.sv
// Combinational GF(2^8) multiplier over GF_POLY, shift-and-add form.
import ipm_pkg::*;

module gmul8 (
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic [7:0] p
);

  logic [7:0] acc;
  logic [7:0] term;

  // term walks through a*x^i, reduced each step so it never exceeds 8 bits
  always_comb begin
    acc  = 8'h00;
    term = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ term;
      term = {term[6:0], 1'b0} ^ (term[7] ? GF_POLY[7:0] : 8'h00);
    end
    p = acc;
  end

endmodule

// File: rtl/ipm_decode_serial.sv
// Serial IPM decoder: x = XOR_i gmul8(L_i, c_i), one share per cycle through a
// single shared multiplier, with a valid/ready handshake on both sides.
import ipm_pkg::*;

module ipm_decode_serial #(
  parameter int V = 3
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [V*8-1:0] L,
  input  logic [V*8-1:0] c,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [7:0]     x
);

  localparam int CNT_W = $clog2(V);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(V - 1);

  ipm_state_t       state;
  logic [V*8-1:0]   l_reg;
  logic [V*8-1:0]   c_reg;
  logic [7:0]       acc;
  logic [CNT_W-1:0] cnt;
  logic [7:0]       l_sel;
  logic [7:0]       c_sel;
  logic [7:0]       prod;
  logic [7:0]       acc_next;

  assign l_sel    = l_reg[int'(cnt)*8 +: 8];
  assign c_sel    = c_reg[int'(cnt)*8 +: 8];
  assign acc_next = acc ^ prod;

  gmul8 u_gmul8 (
    .a (l_sel),
    .b (c_sel),
    .p (prod)
  );

  // x is loaded only when the last share lands, so partial sums never reach it
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      l_reg     <= '0;
      c_reg     <= '0;
      acc       <= 8'h00;
      cnt       <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      x         <= 8'h00;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            l_reg    <= L;
            c_reg    <= c;
            acc      <= 8'h00;
            cnt      <= '0;
            in_ready <= 1'b0;
            state    <= ACCUM;
          end
        end
        ACCUM: begin
          acc <= acc_next;
          if (cnt == LAST) begin
            x         <= acc_next;
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            x         <= 8'h00;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          x         <= 8'h00;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ipm_decode_serial.sv
// Scoreboard bench for ipm_decode_serial: directed vectors on a V=3 instance,
// plus random inner-product regression on V=2, V=3 and V=5 instances.
module tb_ipm_decode_serial;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // V=3 instance, checked through the scoreboard
  logic        iv3, ir3, ov3, ordy3;
  logic [23:0] l3, c3;
  logic [7:0]  x3;

  // V=2 and V=5 instances for the random regression
  logic        iv2, ir2, ov2, ordy2;
  logic [15:0] l2, c2;
  logic [7:0]  x2;
  logic        iv5, ir5, ov5, ordy5;
  logic [39:0] l5, c5;
  logic [7:0]  x5;

  ipm_decode_serial #(.V(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv3), .in_ready(ir3), .L(l3), .c(c3),
    .out_valid(ov3), .out_ready(ordy3), .x(x3));

  ipm_decode_serial #(.V(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv2), .in_ready(ir2), .L(l2), .c(c2),
    .out_valid(ov2), .out_ready(ordy2), .x(x2));

  ipm_decode_serial #(.V(5)) dut5 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv5), .in_ready(ir5), .L(l5), .c(c5),
    .out_valid(ov5), .out_ready(ordy5), .x(x5));

  typedef struct {
    logic [7:0] x;
    int         cyc;
  } exp_t;
  exp_t sb[$];

  // Full polynomial product first, then reduce from the top bit down
  function automatic logic [7:0] ref_mul(logic [7:0] a, logic [7:0] b);
    logic [14:0] p;
    p = '0;
    for (int i = 0; i < 8; i++)
      if (b[i]) p = p ^ (15'(a) << i);
    for (int k = 14; k >= 8; k--)
      if (p[k]) p = p ^ (15'(9'h11B) << (k - 8));
    return p[7:0];
  endfunction

  function automatic logic [7:0] ref_ip(int v, logic [39:0] l, logic [39:0] c);
    logic [7:0] r;
    r = 8'h00;
    for (int i = 0; i < v; i++) r = r ^ ref_mul(l[i*8 +: 8], c[i*8 +: 8]);
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Offer one encoding on the V=3 instance; called at posedge+#1
  task automatic applyStimulus(input logic [23:0] l, input logic [23:0] c, input logic [7:0] exp,
                               input bit keep_valid, input bit expect_out, output int acc_cyc);
    int n;
    iv3 = 1'b1;
    l3  = l;
    c3  = c;
    n   = 0;
    while (!ir3 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput("accept_ready", 32'(ir3), 32'd1);
    acc_cyc = -1;
    if (!ir3) begin
      iv3 = 1'b0;
      return;
    end
    @(posedge clk); #1;
    acc_cyc = cyc;
    if (expect_out) sb.push_back('{exp, cyc + 3});
    l3  = 24'($urandom);
    c3  = 24'($urandom);
    iv3 = keep_valid;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput("drain", 32'(sb.size()), 32'd0);
  endtask

  // Monitor: compares each presented result against the head of the scoreboard
  bit         seen = 1'b0;
  logic [7:0] held;
  always @(negedge clk) begin
    if (!rst_n) begin
      seen = 1'b0;
    end else if (ov3) begin
      if (!seen) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_out_valid: got x=0x%0h with nothing outstanding (cycle %0d)", x3, cyc);
        end else begin
          checkOutput("result_x", 32'(x3), 32'(sb[0].x));
          checkOutput("latency", 32'(cyc), 32'(sb[0].cyc));
          held = x3;
          seen = 1'b1;
        end
      end else begin
        checkOutput("hold_x", 32'(x3), 32'(held));
      end
      checkOutput("busy_in_ready", 32'(ir3), 32'd0);
      if (ordy3) begin
        if (sb.size() != 0) void'(sb.pop_front());
        seen = 1'b0;
      end
    end else begin
      checkOutput("idle_x_zero", 32'(x3), 32'd0);
    end
  end

  task automatic runRandom2();
    logic [7:0] exp;
    int n;
    for (int k = 0; k < 1000; k++) begin
      iv2 = 1'b1;
      l2  = 16'($urandom);
      c2  = 16'($urandom);
      exp = ref_ip(2, 40'(l2), 40'(c2));
      checkOutput("v2_in_ready", 32'(ir2), 32'd1);
      @(posedge clk); #1;
      iv2 = 1'b0;
      l2  = 16'($urandom);
      n   = 0;
      while (!ov2 && n < 20) begin
        @(posedge clk); #1;
        n++;
      end
      checkOutput("v2_valid", 32'(ov2), 32'd1);
      checkOutput("v2_x", 32'(x2), 32'(exp));
      @(posedge clk); #1;
    end
  endtask

  task automatic runRandom5();
    logic [7:0] exp;
    int n;
    for (int k = 0; k < 1000; k++) begin
      iv5 = 1'b1;
      l5  = 40'({$urandom, $urandom});
      c5  = 40'({$urandom, $urandom});
      exp = ref_ip(5, l5, c5);
      checkOutput("v5_in_ready", 32'(ir5), 32'd1);
      @(posedge clk); #1;
      iv5 = 1'b0;
      c5  = 40'({$urandom, $urandom});
      n   = 0;
      while (!ov5 && n < 20) begin
        @(posedge clk); #1;
        n++;
      end
      checkOutput("v5_valid", 32'(ov5), 32'd1);
      checkOutput("v5_x", 32'(x5), 32'(exp));
      @(posedge clk); #1;
    end
  endtask

  task automatic runRandom3();
    logic [23:0] l, c;
    int a;
    for (int k = 0; k < 1000; k++) begin
      l = 24'($urandom);
      c = 24'($urandom);
      applyStimulus(l, c, ref_ip(3, 40'(l), 40'(c)), 1'b0, 1'b1, a);
    end
    drain();
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL global_timeout: simulation did not complete (cycle %0d)", cyc);
    $fatal(1, "[TB] timeout");
  end

  initial begin
    int a1, a2;
    rst_n = 1'b0;
    iv3 = 1'b0; l3 = '0; c3 = '0; ordy3 = 1'b1;
    iv2 = 1'b0; l2 = '0; c2 = '0; ordy2 = 1'b1;
    iv5 = 1'b0; l5 = '0; c5 = '0; ordy5 = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    checkOutput("reset_out_valid", 32'(ov3), 32'd0);
    checkOutput("reset_x", 32'(x3), 32'd0);
    checkOutput("reset_in_ready", 32'(ir3), 32'd1);

    $display("[TB] known vector");
    applyStimulus(24'h138301, 24'h5757AA, 8'h95, 1'b0, 1'b1, a1);
    drain();

    $display("[TB] zero shares");
    applyStimulus(24'hA5C3F1, 24'h000000, 8'h00, 1'b0, 1'b1, a1);
    drain();

    $display("[TB] back-to-back with input changes");
    applyStimulus(24'h010101, 24'h563412, 8'h70, 1'b1, 1'b1, a1);
    applyStimulus(24'h030201, 24'h020305, 8'h05, 1'b0, 1'b1, a2);
    checkOutput("b2b_accept_gap", 32'(a2 - a1), 32'd5);
    drain();

    $display("[TB] backpressure");
    ordy3 = 1'b0;
    applyStimulus(24'h000002, 24'h000080, 8'h1B, 1'b0, 1'b1, a1);
    begin
      int n;
      n = 0;
      while (!ov3 && n < 20) begin
        @(posedge clk); #1;
        n++;
      end
    end
    checkOutput("bp_valid", 32'(ov3), 32'd1);
    repeat (5) begin
      @(posedge clk); #1;
    end
    checkOutput("bp_still_valid", 32'(ov3), 32'd1);
    ordy3 = 1'b1;
    @(posedge clk); #1;
    checkOutput("bp_done_valid", 32'(ov3), 32'd0);
    checkOutput("bp_done_in_ready", 32'(ir3), 32'd1);
    drain();

    $display("[TB] reset mid-operation");
    applyStimulus(24'h138301, 24'h5757AA, 8'h95, 1'b0, 1'b0, a1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    checkOutput("abort_out_valid", 32'(ov3), 32'd0);
    checkOutput("abort_x", 32'(x3), 32'd0);
    checkOutput("abort_in_ready", 32'(ir3), 32'd1);
    repeat (10) begin
      @(posedge clk); #1;
    end
    applyStimulus(24'h030201, 24'h020305, 8'h05, 1'b0, 1'b1, a1);
    drain();

    $display("[TB] random regression");
    fork
      runRandom2();
      runRandom3();
      runRandom5();
    join

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
